// File: rtl/nand_bist.sv
// ---------------------------------------------------------------------------
// nand_bist -- built-in self-test sequencer for a single two-input gate.
//
// Applies the four input vectors {a,b} = 00, 01, 10, 11 in order. Each vector
// is held for one APPLY cycle, SETTLE settle cycles and one SAMPLE cycle. In
// SAMPLE the gate output is compared against EXPECT[vec], and any mismatch is
// recorded in fail_mask and err_count.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a run (level-sampled in IDLE/DONE)
//   abort      return to IDLE and clear results (wins over start)
//   a_out      registered stimulus, gate input a
//   b_out      registered stimulus, gate input b
//   c_in       gate output, sampled in SAMPLE only
//   busy       run in progress (APPLY/SETTLE/SAMPLE)
//   done       results valid (DONE state)
//   pass       done and no mismatches
//   err_count  number of mismatching vectors (0..4)
//   fail_mask  bit i set when vector i mismatched
//
// state  | meaning
// IDLE   | waiting for start, stimulus driven to 00
// APPLY  | new vector driven onto a_out/b_out
// SETTLE | SETTLE-cycle wait, down-counter running
// SAMPLE | compare c_in against EXPECT[vec]
// DONE   | results held until start or abort
// ---------------------------------------------------------------------------
module nand_bist #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXPECT = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // The counter is loaded with SETTLE-1 so that the SETTLE state lasts
    // exactly SETTLE cycles before the terminal count at zero.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ab_q, ab_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        err_d   = err_q;
        mask_d  = mask_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = 2'd0;
                    ab_d    = 2'b00;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                end
            end
            S_APPLY: begin
                if (SETTLE > 0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (c_in != EXPECT[vec_q]) begin
                    mask_d[vec_q] = 1'b1;
                    if (err_q != 3'd4) begin
                        err_d = err_q + 3'd1;
                    end
                end
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                    vec_d   = vec_q + 2'd1;
                    ab_d    = vec_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            vec_d   = 2'd0;
            cnt_d   = 4'd0;
            ab_d    = 2'b00;
            err_d   = 3'd0;
            mask_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            ab_q    <= 2'b00;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == 3'd0);
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_nand_bist.sv
module tb_nand_bist;

    localparam logic [3:0] NAND_TT = 4'b0111;

    typedef struct {
        int         lat;
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start2, abort2, start0, abort0;
    int   mode;   // 0: NAND, 1: output stuck at 0, 2: AND gate
    logic sel;    // 0: SETTLE=2 instance, 1: SETTLE=0 instance

    logic a_out2, b_out2, c_in2, busy2, done2, pass2;
    logic a_out0, b_out0, c_in0, busy0, done0, pass0;
    logic [2:0] err2, err0;
    logic [3:0] mask2, mask0;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    function automatic logic gate_f(input logic a, input logic b, input int m);
        if (m == 1) return 1'b0;
        if (m == 2) return a & b;
        return ~(a & b);
    endfunction

    assign c_in2 = gate_f(a_out2, b_out2, mode);
    assign c_in0 = gate_f(a_out0, b_out0, mode);

    nand_bist dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .c_in(c_in2),
        .a_out(a_out2), .b_out(b_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(mask2)
    );

    nand_bist #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .c_in(c_in0),
        .a_out(a_out0), .b_out(b_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_mask(mask0)
    );

    logic       cur_a, cur_b, cur_busy, cur_done, cur_pass;
    logic [2:0] cur_err;
    logic [3:0] cur_mask;
    assign cur_a    = sel ? a_out0 : a_out2;
    assign cur_b    = sel ? b_out0 : b_out2;
    assign cur_busy = sel ? busy0  : busy2;
    assign cur_done = sel ? done0  : done2;
    assign cur_pass = sel ? pass0  : pass2;
    assign cur_err  = sel ? err0   : err2;
    assign cur_mask = sel ? mask0  : mask2;

    function automatic exp_t model(input int m, input int s);
        exp_t x;
        logic [1:0] v;
        logic g;
        x.lat  = 4 * (s + 2);
        x.err  = 3'd0;
        x.mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            g = gate_f(v[1], v[0], m);
            if (g !== NAND_TT[i]) begin
                x.mask[i] = 1'b1;
                x.err     = x.err + 3'd1;
            end
        end
        x.pass = (x.err == 3'd0);
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic v);
        if (sel) start0 = v; else start2 = v;
    endtask

    // Pulses start, then follows the run until done rises (bounded). Counts
    // cycles where the applied vector or busy disagrees with the schedule.
    task automatic do_run(input bit pulse_busy, output int lat, output int seq_bad,
                          output logic [2:0] e0, output logic [3:0] m0,
                          output logic d0);
        int s;
        s = sel ? 0 : 2;
        sb.push_back(model(mode, s));
        drive_start(1'b1);
        tick();
        drive_start(1'b0);
        e0 = cur_err;
        m0 = cur_mask;
        d0 = cur_done;
        lat = -1;
        seq_bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (cur_done === 1'b1) begin
                lat = k;
                break;
            end
            if ({cur_a, cur_b} !== 2'(k / (s + 2)) || cur_busy !== 1'b1) seq_bad++;
            if (pulse_busy) drive_start(((k % 3) == 0) && (k < 4 * (s + 2) - 1));
            tick();
        end
        drive_start(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        mode = 0; sel = 1'b0;
        tick(); tick();
        checks++;
        if ({a_out2, b_out2, busy2, done2, pass2, err2, mask2} !== 12'd0) begin
            failures++;
            $display("FAIL reset_s2: got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b, want all 0",
                     a_out2, b_out2, busy2, done2, pass2, err2, mask2);
        end
        checks++;
        if ({a_out0, b_out0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
            failures++;
            $display("FAIL reset_s0: got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b, want all 0",
                     a_out0, b_out0, busy0, done0, pass0, err0, mask0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nand();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b0; mode = 0;
        do_run(1'b0, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat) begin failures++; $display("FAIL nand_latency: got %0d want %0d", lat, x.lat); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL nand_sequence: got %0d bad cycles want 0", bad); end
        checks++;
        if (cur_pass !== x.pass || cur_err !== x.err || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL nand_result: got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
                     cur_pass, cur_err, cur_mask, x.pass, x.err, x.mask);
        end
        repeat (3) tick();
        checks++;
        if (cur_done !== 1'b1 || cur_pass !== 1'b1 || {cur_a, cur_b} !== 2'b11) begin
            failures++;
            $display("FAIL nand_done_hold: got done=%b pass=%b ab=%b%b want done=1 pass=1 ab=11",
                     cur_done, cur_pass, cur_a, cur_b);
        end
    endtask

    task automatic test_stuck0();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b0; mode = 1;
        do_run(1'b0, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || bad !== 0) begin
            failures++; $display("FAIL stuck0_timing: got lat=%0d bad=%0d want lat=%0d bad=0", lat, bad, x.lat);
        end
        checks++;
        if (cur_pass !== x.pass || cur_err !== x.err || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL stuck0_result: got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
                     cur_pass, cur_err, cur_mask, x.pass, x.err, x.mask);
        end
    endtask

    task automatic test_and_restart();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b0; mode = 2;
        do_run(1'b0, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (e0 !== 3'd0 || m0 !== 4'd0 || d0 !== 1'b0) begin
            failures++;
            $display("FAIL restart_clears: got err=%0d mask=%b done=%b want err=0 mask=0000 done=0", e0, m0, d0);
        end
        checks++;
        if (lat !== x.lat || bad !== 0) begin
            failures++; $display("FAIL and_timing: got lat=%0d bad=%0d want lat=%0d bad=0", lat, bad, x.lat);
        end
        checks++;
        if (cur_pass !== x.pass || cur_err !== x.err || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL and_result: got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
                     cur_pass, cur_err, cur_mask, x.pass, x.err, x.mask);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b0; mode = 1;
        do_run(1'b1, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || bad !== 0) begin
            failures++; $display("FAIL busy_ignore_timing: got lat=%0d bad=%0d want lat=%0d bad=0", lat, bad, x.lat);
        end
        checks++;
        if (cur_err !== x.err || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL busy_ignore_result: got err=%0d mask=%b want err=%0d mask=%b",
                     cur_err, cur_mask, x.err, x.mask);
        end
    endtask

    task automatic test_abort_wins();
        sel = 1'b0;
        start2 = 1'b1; abort2 = 1'b1;
        tick();
        start2 = 1'b0; abort2 = 1'b0;
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || mask2 !== 4'd0 || pass2 !== 1'b0) begin
            failures++;
            $display("FAIL abort_wins: got done=%b busy=%b mask=%b pass=%b want 0 0 0000 0",
                     done2, busy2, mask2, pass2);
        end
    endtask

    task automatic test_abort();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b0; mode = 1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (9) tick();   // vector 10 has just entered SETTLE
        checks++;
        if (mask2 !== 4'b0011 || {a_out2, b_out2} !== 2'b10) begin
            failures++;
            $display("FAIL abort_pre: got mask=%b ab=%b%b want mask=0011 ab=10", mask2, a_out2, b_out2);
        end
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || {a_out2, b_out2} !== 2'b00 || mask2 !== 4'd0 || err2 !== 3'd0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b done=%b ab=%b%b mask=%b err=%0d want 0 0 00 0000 0",
                     busy2, done2, a_out2, b_out2, mask2, err2);
        end
        mode = 0;
        do_run(1'b0, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || bad !== 0 || cur_pass !== x.pass || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL abort_rerun: got lat=%0d bad=%0d pass=%b mask=%b want lat=%0d bad=0 pass=%b mask=%b",
                     lat, bad, cur_pass, cur_mask, x.lat, x.pass, x.mask);
        end
    endtask

    task automatic test_rst_midrun();
        int lat;
        sel = 1'b0; mode = 1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (6) tick();
        rst = 1'b1; start2 = 1'b1; mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy2 !== 1'b0 || done2 !== 1'b0 || mask2 !== 4'd0 || err2 !== 3'd0 || {a_out2, b_out2} !== 2'b00) begin
                failures++;
                $display("FAIL rst_hold_%0d: got busy=%b done=%b mask=%b err=%0d ab=%b%b want all 0",
                         i, busy2, done2, mask2, err2, a_out2, b_out2);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy2 !== 1'b1 || {a_out2, b_out2} !== 2'b00) begin
            failures++; $display("FAIL rst_release_start: got busy=%b ab=%b%b want busy=1 ab=00", busy2, a_out2, b_out2);
        end
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done2 === 1'b1) begin lat = k; break; end
            tick();
        end
        checks++;
        if (lat !== 16 || pass2 !== 1'b1) begin
            failures++; $display("FAIL rst_held_start_run: got lat=%0d pass=%b want lat=16 pass=1", lat, pass2);
        end
        tick();   // start still high: DONE restarts immediately
        checks++;
        if (busy2 !== 1'b1 || done2 !== 1'b0 || pass2 !== 1'b0) begin
            failures++; $display("FAIL held_start_restart: got busy=%b done=%b pass=%b want 1 0 0", busy2, done2, pass2);
        end
        start2 = 1'b0;
        for (int k = 0; k < 100 && done2 !== 1'b1; k++) tick();
        checks++;
        if (done2 !== 1'b1) begin failures++; $display("FAIL held_start_finish: got done=%b want 1", done2); end
    endtask

    task automatic test_settle0();
        int lat, bad; logic [2:0] e0; logic [3:0] m0; logic d0; exp_t x;
        sel = 1'b1; mode = 0;
        do_run(1'b0, lat, bad, e0, m0, d0);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat) begin failures++; $display("FAIL settle0_latency: got %0d want %0d", lat, x.lat); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL settle0_hold: got %0d bad cycles want 0", bad); end
        checks++;
        if (cur_pass !== x.pass || cur_err !== x.err || cur_mask !== x.mask) begin
            failures++;
            $display("FAIL settle0_result: got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
                     cur_pass, cur_err, cur_mask, x.pass, x.err, x.mask);
        end
    endtask

    initial begin
        test_reset();
        test_nand();
        test_stuck0();
        test_and_restart();
        test_busy_ignore();
        test_abort_wins();
        test_abort();
        test_rst_midrun();
        test_settle0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_bist.md
NAND_BIST -- requirements
Module: nand_bist

Interface
REQ-001 Parameter SETTLE, default 2: idle cycles between applying a vector and sampling the gate output; legal range 0..15.
REQ-002 Parameter EXPECT, default 4'b0111: expected gate output for each vector, with bit i for vector i = {a,b}; the default is the NAND truth table.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a self-test run; level-sampled.
REQ-006 abort  input  1  terminate any run and return to idle.
REQ-007 a_out  output  1  registered stimulus to the gate-under-test input a.
REQ-008 b_out  output  1  registered stimulus to the gate-under-test input b.
REQ-009 c_in  input  1  gate-under-test output; sampled only in SAMPLE state.
REQ-010 busy  output  1  high while a run is in progress (APPLY/SETTLE/SAMPLE).
REQ-011 done  output  1  high while in DONE state.
REQ-012 pass  output  1  valid when done=1: high iff err_count==0.
REQ-013 err_count  output  3  number of mismatching vectors in the current/last run (0..4).
REQ-014 fail_mask  output  4  bit i set iff vector i mismatched.

Function
REQ-015 The FSM SHALL have the states IDLE, APPLY, SETTLE, SAMPLE, DONE, with a 2-bit vector index vec.
REQ-016 IDLE: busy=0, done=0, a_out=b_out=0; start=1 -> APPLY with vec=0, err_count=0, fail_mask=0, {a_out,b_out}=2'b00 at the same edge.
REQ-017 APPLY: lasts exactly one cycle with {a_out,b_out}={vec}; next state is SETTLE if SETTLE>0, else SAMPLE.
REQ-018 SETTLE: lasts exactly SETTLE cycles (internal down-counter), outputs held, then SAMPLE.
REQ-019 SAMPLE: lasts one cycle; if c_in != EXPECT[vec], set fail_mask[vec] and increment err_count at that edge.
REQ-020 After SAMPLE with vec<3: vec increments, {a_out,b_out} updates to the new vec at the same edge, and the state returns to APPLY.
REQ-021 After SAMPLE with vec==3: state -> DONE; a_out/b_out hold 2'b11.
REQ-022 Vectors SHALL be applied in the order 00, 01, 10, 11; each vector occupies SETTLE+2 cycles.
REQ-023 Latency: done SHALL rise exactly 4*(SETTLE+2) rising edges after the edge at which start was sampled in IDLE; this is 16 edges at the default.
REQ-024 DONE: done=1, pass=(err_count==0); err_count and fail_mask are held; state stays in DONE until start or abort.
REQ-025 start=1 in DONE SHALL restart exactly as from IDLE, clearing the results at that edge; done falls at that edge.
REQ-026 start while busy=1 SHALL be ignored; the run is unaffected.
REQ-027 abort=1 in any state SHALL go to IDLE at the next edge, clearing a_out, b_out, done, pass, err_count, fail_mask and vec.
REQ-028 If start and abort are both high, abort wins.
REQ-029 err_count SHALL saturate at 4 and cannot wrap; the 3-bit width makes wrap impossible.
REQ-030 pass SHALL be 0 whenever done=0.

Reset
REQ-031 rst=1 at a rising edge SHALL force state IDLE, vec=0, and the SETTLE counter to 0.
REQ-032 The same edge SHALL force a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
REQ-033 rst SHALL override start and abort, and SHALL take effect mid-run; no result of the interrupted run survives.
REQ-034 Outputs SHALL be valid from the first edge with rst=1; no asynchronous path is permitted.

Verification
REQ-035 Correct NAND on c_in, SETTLE=2, start pulsed one cycle -> done rises 16 edges later, pass=1, err_count=0, fail_mask=0000; a_out/b_out sequence 00,01,10,11.
REQ-036 c_in stuck at 0 -> fail_mask=0111, err_count=3, pass=0.
REQ-037 AND gate in place of the NAND -> fail_mask=1111, err_count=4, pass=0.
REQ-038 abort on the cycle after vector 10 enters SETTLE -> next edge IDLE, busy=0, a_out=b_out=0, fail_mask=0; start again completes normally.
REQ-039 rst asserted mid-run, then start held high continuously -> run restarts only after rst deasserts; start pulses while busy have no effect; start in DONE clears the previous failures before the new run.
REQ-040 SETTLE=0 with a correct NAND -> done 8 edges after start, pass=1; check that each vector is held for exactly 2 cycles.
